// File: rtl/exe_div_ctrl_if.sv
// Request/result bundle between the exe stage and the divide sequencer.
// master: exe-stage side (drives the request and flush, receives ready, stall and result).
// slave : divider side (receives the request, returns ready, stall and the one-beat result).
interface exe_div_ctrl_if #(
    parameter int XLEN = 64
);
    logic            div_valid_i;
    logic [1:0]      div_op_i;
    logic            div_word_i;
    logic [XLEN-1:0] op1_i;
    logic [XLEN-1:0] op2_i;
    logic            flush_i;
    logic            div_ready_o;
    logic            stall_exe_o;
    logic            res_valid_o;
    logic [XLEN-1:0] res_data_o;

    modport master (
        output div_valid_i, div_op_i, div_word_i, op1_i, op2_i, flush_i,
        input  div_ready_o, stall_exe_o, res_valid_o, res_data_o
    );

    modport slave (
        input  div_valid_i, div_op_i, div_word_i, op1_i, op2_i, flush_i,
        output div_ready_o, stall_exe_o, res_valid_o, res_data_o
    );
endinterface

// File: rtl/exe_div_ctrl.sv
// Purpose : RV64M DIV/DIVU/REM/REMU sequencer, radix-2 restoring, one quotient bit per cycle.
// Latency : result beat N+1 cycles after accept (N=64, or 32 for W ops); /0 and MIN/-1 in 1 cycle.
// Backpr. : single request in flight; ready only in IDLE, exe held by stall_exe_o while busy.
// Ports   : clk, rst_n (async active-low); bus (exe_div_ctrl_if.slave) carries request
//           (div_valid_i, div_op_i, div_word_i, op1_i, op2_i, flush_i) and response
//           (div_ready_o, stall_exe_o, res_valid_o, res_data_o).
// Config  : define EXE_DIV_WORD_EN to honour div_word_i (DIVW/DIVUW/REMW/REMUW).
module exe_div_ctrl #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    exe_div_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0] quo_q;      // dividend shifts out the top, quotient bits shift in below
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] dvs_q;      // divisor magnitude
    logic            is_rem_q;
    logic            neg_quo_q;
    logic            neg_rem_q;
`ifdef EXE_DIV_WORD_EN
    logic            word_q;
`endif

    // Operand preparation for the accept cycle
    logic            sgn_in;
    logic            word_in;
    logic [XLEN-1:0] a_ext, b_ext, min_val;
    logic [XLEN-1:0] a_abs, b_abs;
    logic            a_neg, b_neg;
    logic            div_zero, ovf, accept;

    always_comb begin
        sgn_in = ~bus.div_op_i[0];
`ifdef EXE_DIV_WORD_EN
        word_in = bus.div_word_i;
        if (word_in) begin
            a_ext   = sgn_in ? {{(XLEN-32){bus.op1_i[31]}}, bus.op1_i[31:0]}
                             : {{(XLEN-32){1'b0}}, bus.op1_i[31:0]};
            b_ext   = sgn_in ? {{(XLEN-32){bus.op2_i[31]}}, bus.op2_i[31:0]}
                             : {{(XLEN-32){1'b0}}, bus.op2_i[31:0]};
            min_val = {{(XLEN-31){1'b1}}, {31{1'b0}}};
        end else begin
            a_ext   = bus.op1_i;
            b_ext   = bus.op2_i;
            min_val = {1'b1, {(XLEN-1){1'b0}}};
        end
`else
        word_in = 1'b0;
        a_ext   = bus.op1_i;
        b_ext   = bus.op2_i;
        min_val = {1'b1, {(XLEN-1){1'b0}}};
`endif
        a_neg    = sgn_in & a_ext[XLEN-1];
        b_neg    = sgn_in & b_ext[XLEN-1];
        a_abs    = a_neg ? -a_ext : a_ext;
        b_abs    = b_neg ? -b_ext : b_ext;
        div_zero = (b_ext == '0);
        ovf      = sgn_in & (a_ext == min_val) & (b_ext == '1);
        accept   = bus.div_valid_i & (state_q == IDLE) & ~bus.flush_i;
    end

`ifndef EXE_DIV_WORD_EN
    logic unused_word;
    assign unused_word = bus.div_word_i | word_in;
`endif

    // One restoring step: shift in next dividend bit, subtract if it fits.
    // Trial is one bit wider so a large divisor cannot wrap the compare.
    logic [XLEN:0]   trial;
    logic            fits;
    logic [XLEN-1:0] rem_nx, quo_nx;

    always_comb begin
        trial  = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};
        fits   = ~trial[XLEN];
        rem_nx = fits ? trial[XLEN-1:0] : {rem_q[XLEN-2:0], quo_q[XLEN-1]};
        quo_nx = {quo_q[XLEN-2:0], fits};
    end

    // Sign fix-up and result select, only meaningful in DONE
    logic [XLEN-1:0] quo_fix, rem_fix, res_sel, res_full;

    always_comb begin
        quo_fix  = neg_quo_q ? -quo_q : quo_q;
        rem_fix  = neg_rem_q ? -rem_q : rem_q;
        res_sel  = is_rem_q ? rem_fix : quo_fix;
        res_full = res_sel;
`ifdef EXE_DIV_WORD_EN
        if (word_q) res_full = {{(XLEN-32){res_sel[31]}}, res_sel[31:0]};
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d         = state_q;
        bus.div_ready_o = (state_q == IDLE);
        bus.stall_exe_o = 1'b0;
        bus.res_valid_o = 1'b0;
        bus.res_data_o  = '0;
        case (state_q)
            IDLE: begin
                bus.stall_exe_o = bus.div_valid_i & ~bus.flush_i;
                if (accept) state_d = (div_zero | ovf) ? DONE : CALC;
            end
            CALC: begin
                bus.stall_exe_o = 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = DONE;
            end
            DONE: begin
                bus.res_valid_o = ~bus.flush_i;
                bus.res_data_o  = bus.flush_i ? '0 : res_full;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (bus.flush_i) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
`ifdef EXE_DIV_WORD_EN
            word_q    <= 1'b0;
`endif
        end else if (bus.flush_i) begin
            cnt_q <= '0;
        end else if (accept) begin
            is_rem_q  <= bus.div_op_i[1];
`ifdef EXE_DIV_WORD_EN
            word_q    <= word_in;
`endif
            dvs_q     <= b_abs;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= '0;
            if (div_zero) begin
                // Results land pre-signed, so fix-up stays disabled
                quo_q <= '1;
                rem_q <= a_ext;
            end else if (ovf) begin
                quo_q <= a_ext;
                rem_q <= '0;
            end else begin
                // W ops start with the 32-bit magnitude at the top so the
                // first 32 shifts consume exactly the dividend bits
                quo_q     <= word_in ? {a_abs[31:0], {(XLEN-32){1'b0}}} : a_abs;
                rem_q     <= '0;
                neg_quo_q <= a_neg ^ b_neg;
                neg_rem_q <= a_neg;
                cnt_q     <= word_in ? CNT_W'(XLEN/2) : CNT_W'(XLEN);
            end
        end else if (state_q == CALC) begin
            quo_q <= quo_nx;
            rem_q <= rem_nx;
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_exe_div_ctrl.sv
module tb_exe_div_ctrl;
    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    exe_div_ctrl_if #(.XLEN(64)) bus_if();

    exe_div_ctrl #(.XLEN(64), .CNT_W(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    typedef struct {
        logic [63:0] data;
        int          due;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // Reference model: architectural RV64M results from plain arithmetic
    function automatic logic [63:0] ref_div(input logic [1:0] op, input bit w,
                                            input logic [63:0] a_in, input logic [63:0] b_in,
                                            output int lat);
        logic [63:0] a, b, q, r, res;
        logic signed [63:0] sa, sbv;
        bit sgn, use_w;
        sgn = (op[0] == 1'b0);
`ifdef EXE_DIV_WORD_EN
        use_w = w;
`else
        use_w = 1'b0;
`endif
        a = a_in;
        b = b_in;
        if (use_w) begin
            a = sgn ? {{32{a_in[31]}}, a_in[31:0]} : {32'd0, a_in[31:0]};
            b = sgn ? {{32{b_in[31]}}, b_in[31:0]} : {32'd0, b_in[31:0]};
        end
        lat = use_w ? 33 : 65;
        if (b == 64'd0) begin
            q = ONES;
            r = a;
            lat = 1;
        end else if (sgn && b == ONES &&
                     a == (use_w ? 64'hFFFF_FFFF_8000_0000 : MIN64)) begin
            q = a;
            r = 64'd0;
            lat = 1;
        end else if (sgn) begin
            sa  = a;
            sbv = b;
            q = sa / sbv;
            r = sa % sbv;
        end else begin
            q = a / b;
            r = a % b;
        end
        res = op[1] ? r : q;
        if (use_w) res = {{32{res[31]}}, res[31:0]};
        return res;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every result beat
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_if.res_valid_o) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result: got %h at cycle %0d expected no beat",
                             bus_if.res_data_o, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (bus_if.res_data_o !== mon_e.data || cyc != mon_e.due) begin
                        errors++;
                        $display("FAIL %s: got %h at cycle %0d expected %h at cycle %0d",
                                 mon_e.name, bus_if.res_data_o, cyc, mon_e.data, mon_e.due);
                    end
                end
            end else begin
                chk("res_data_idle", bus_if.res_data_o, 64'd0);
            end
        end
    end

    // Issue one request, hold it until the result beat, then drop it.
    // Called just after a negedge.
    task automatic run_op(input string name, input logic [1:0] op, input bit w,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp_data, input int exp_lat);
        exp_t e;
        bit   got;
        int   n;
        n = 0;
        while (!bus_if.div_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        bus_if.div_valid_i = 1'b1;
        bus_if.div_op_i    = op;
        bus_if.div_word_i  = w;
        bus_if.op1_i       = a;
        bus_if.op2_i       = b;
        #1;
        chk({name, "_ready"}, {63'd0, bus_if.div_ready_o}, 64'd1);
        chk({name, "_stall"}, {63'd0, bus_if.stall_exe_o}, 64'd1);
        e.data = exp_data;
        e.due  = cyc + exp_lat;
        e.name = name;
        exp_q.push_back(e);
        got = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus_if.res_valid_o) begin
                got = 1'b1;
                break;
            end
        end
        if (got) begin
            chk({name, "_stall_done"}, {63'd0, bus_if.stall_exe_o}, 64'd0);
        end else begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no result beat expected one within 100 cycles", name);
            if (exp_q.size() != 0) void'(exp_q.pop_back());
        end
        bus_if.div_valid_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_model(input string name, input logic [1:0] op, input bit w,
                             input logic [63:0] a, input logic [63:0] b);
        logic [63:0] d;
        int lat;
        d = ref_div(op, w, a, b, lat);
        run_op(name, op, w, a, b, d, lat);
    endtask

    function automatic logic [63:0] rand_operand();
        logic [63:0] v;
        case ($urandom_range(0, 7))
            0: v = MIN64;
            1: v = ONES;
            2: v = 64'd0;
            3: v = 64'($urandom_range(1, 20));
            4: v = {32'd0, 32'($urandom)};
            5: v = {{32{1'b1}}, 32'($urandom)};
            6: v = 64'h0000_0000_8000_0000;
            default: v = {32'($urandom), 32'($urandom)};
        endcase
        return v;
    endfunction

    initial begin
        logic [63:0] a, b;
        logic [1:0]  op;
        bit          w;

        rst_n              = 1'b0;
        bus_if.div_valid_i = 1'b0;
        bus_if.div_op_i    = 2'b00;
        bus_if.div_word_i  = 1'b0;
        bus_if.op1_i       = 64'd0;
        bus_if.op2_i       = 64'd0;
        bus_if.flush_i     = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {63'd0, bus_if.div_ready_o}, 64'd1);
        chk("rst_stall", {63'd0, bus_if.stall_exe_o}, 64'd0);
        chk("rst_valid", {63'd0, bus_if.res_valid_o}, 64'd0);
        chk("rst_data",  bus_if.res_data_o, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases with hand-derived expectations
        run_op("divu_100_7", 2'b01, 1'b0, 64'd100, 64'd7, 64'd14, 65);
        run_op("remu_100_7", 2'b11, 1'b0, 64'd100, 64'd7, 64'd2, 65);
        run_op("rem_m7_2",   2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 65);
        run_op("div_m7_2",   2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
        run_op("div_by0",    2'b00, 1'b0, 64'd12345, 64'd0, ONES, 1);
        run_op("rem_by0",    2'b10, 1'b0, 64'd12345, 64'd0, 64'd12345, 1);
        run_op("divu_by0",   2'b01, 1'b0, 64'd77, 64'd0, ONES, 1);
        run_op("div_ovf",    2'b00, 1'b0, MIN64, ONES, MIN64, 1);
        run_op("rem_ovf",    2'b10, 1'b0, MIN64, ONES, 64'd0, 1);
        run_op("divu_min_m1", 2'b01, 1'b0, MIN64, ONES, 64'd0, 65);
        run_op("div_min_1",  2'b00, 1'b0, MIN64, 64'd1, MIN64, 65);
`ifdef EXE_DIV_WORD_EN
        run_op("divw_ovf",   2'b00, 1'b1, 64'h1234_5678_8000_0000, ONES, 64'hFFFF_FFFF_8000_0000, 1);
        run_op("divuw_fffe", 2'b01, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 33);
        run_op("remw_m7_2",  2'b10, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, ONES, 33);
`else
        run_op("divw_ignored",  2'b00, 1'b1, 64'h1234_5678_8000_0000, ONES, 64'hEDCB_A987_8000_0000, 65);
        run_op("divuw_ignored", 2'b01, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd1, 64'h0000_0000_FFFF_FFFE, 65);
`endif

        // Flush mid-calculation: no beat for the aborted op
        bus_if.div_valid_i = 1'b1;
        bus_if.div_op_i    = 2'b01;
        bus_if.div_word_i  = 1'b0;
        bus_if.op1_i       = 64'd100;
        bus_if.op2_i       = 64'd7;
        repeat (10) @(negedge clk);
        bus_if.flush_i     = 1'b1;
        bus_if.div_valid_i = 1'b0;
        #1;
        chk("flush_no_valid", {63'd0, bus_if.res_valid_o}, 64'd0);
        @(negedge clk);
        bus_if.flush_i = 1'b0;
        chk("flush_idle_ready", {63'd0, bus_if.div_ready_o}, 64'd1);
        repeat (70) @(negedge clk);
        run_op("after_flush", 2'b01, 1'b0, 64'd100, 64'd7, 64'd14, 65);

        // Flush together with a request in IDLE: not accepted
        bus_if.div_valid_i = 1'b1;
        bus_if.flush_i     = 1'b1;
        #1;
        chk("flush_valid_stall", {63'd0, bus_if.stall_exe_o}, 64'd0);
        @(negedge clk);
        bus_if.div_valid_i = 1'b0;
        bus_if.flush_i     = 1'b0;
        chk("flush_valid_idle", {63'd0, bus_if.div_ready_o}, 64'd1);
        repeat (70) @(negedge clk);

        // Reset in the middle of an operation
        bus_if.div_valid_i = 1'b1;
        bus_if.div_op_i    = 2'b00;
        bus_if.op1_i       = 64'd999;
        bus_if.op2_i       = 64'd3;
        repeat (5) @(negedge clk);
        bus_if.div_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", {63'd0, bus_if.div_ready_o}, 64'd1);
        chk("midrst_stall", {63'd0, bus_if.stall_exe_o}, 64'd0);
        chk("midrst_valid", {63'd0, bus_if.res_valid_o}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (70) @(negedge clk);

        // Randomized traffic against the reference model
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            w  = 1'($urandom_range(0, 1));
            a  = rand_operand();
            b  = rand_operand();
            run_model("rand", op, w, a, b);
        end

        repeat (5) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL leftover: got %0d pending results expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
